nand_sweep_checker: RTL
=======================

Name: nand_sweep_checker

Overview:
- Self-checking stimulus/response partner for the two-input NAND cell.
- Drives the cell's two inputs (clk1, clk2 nets) through the exhaustive 2-bit sweep: input A toggles every step, input B every two steps.
- Samples the cell output after a settle window and compares it against the ideal NAND.
- Records per-vector failures and a saturating error count. Sits in the layout-validation harness between the control logic and the cell under test.

Parameters:
- HOLD, 10, clock cycles each input vector is held. Range 2..255.
- SETTLE, 2, cycle index within the hold window at which dut_out is sampled. Must satisfy SETTLE < HOLD.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep. Sampled only in IDLE.
- dut_out  input  1  output of the NAND cell under test.
- stim_a  output  1  drives cell input clk1 (fast bit, vector bit 0).
- stim_b  output  1  drives cell input clk2 (slow bit, vector bit 1).
- busy  output  1  high while the sweep is running.
- done  output  1  one-cycle pulse at the end of a sweep.
- err_flag  output  1  sticky; set on any mismatch in the current sweep.
- err_count  output  ERR_W  saturating mismatch count.
- fail_vec  output  4  bit k set when vector k ({stim_b,stim_a}=k) mismatched.

Behaviour:
- Reset (async assert, sync release): state IDLE; stim_a=0, stim_b=0, busy=0, done=0, err_flag=0, err_count=0, fail_vec=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 at a clock edge.
  - On that edge: clear err_flag, err_count and fail_vec; vec=0; hold_cnt=0.
  - Results from the previous sweep are held until the next start.
- RUN:
  - {stim_b,stim_a}=vec (2-bit); busy=1.
  - hold_cnt counts 0..HOLD-1. At hold_cnt==HOLD-1, vec increments and hold_cnt returns to 0.
  - Vector k occupies cycles 1+k*HOLD .. (k+1)*HOLD after the start edge (cycle 0).
- Sampling:
  - On the edge where hold_cnt==SETTLE, compare dut_out with expected = ~(stim_a & stim_b).
  - On mismatch: err_flag<=1, fail_vec[vec]<=1, err_count<=err_count+1. err_count saturates at all-ones and never wraps.
  - Results are visible the cycle after the sample edge.
- RUN -> DONE on the edge where vec==3 and hold_cnt==HOLD-1.
- DONE:
  - Lasts one cycle: done=1, busy=0, stim returns to 00.
  - Then -> IDLE.
  - done is high at cycle 4*HOLD+1 after the start edge.
- start while busy or in DONE is ignored; no restart and no re-clear.
- rst_n low mid-sweep: immediate return to IDLE with all outputs at reset values; no done pulse.
- dut_out is treated as already synchronous; no synchronizer in the block.
- Only a single sample per vector; glitches outside the sample edge are ignored.

Optional Feature:
- Macro NANDCHK_CONTINUOUS_EN.
- Defined:
  - Instead of entering DONE after vector 3, the block wraps to vector 0 and stays in RUN while start=1.
  - done pulses for one cycle at each wrap.
  - err_flag, err_count and fail_vec accumulate across sweeps; they are not cleared at the wrap.
  - When start=0 at the end of vector 3, the block goes to DONE, then IDLE.
- Not defined: single sweep per start, exactly as in Behaviour; the start level after launch is ignored.

Test Plan:
- Ideal NAND model on dut_out, HOLD=10, SETTLE=2, start pulse at cycle 0 -> stim sequence 00,01,10,11 each 10 cycles; done=1 at cycle 41 only; err_flag=0, err_count=0, fail_vec=0000.
- dut_out stuck at 1 -> only vector 3 fails: err_count=1, fail_vec=1000, err_flag=1, done at cycle 41.
- dut_out stuck at 0 -> err_count=3, fail_vec=0111. A second start clears the results before the new sweep.
- rst_n low at cycle 15 for 2 cycles -> all outputs 0 and stim=00 immediately; no done pulse. A fresh start then completes a clean 41-cycle sweep.
- start re-pulsed at cycles 5 and 20 during a sweep -> ignored; done still at cycle 41 only; stim timing unchanged.
- NANDCHK_CONTINUOUS_EN defined, ERR_W=2, dut_out stuck at 0, start held high for 3 sweeps -> done pulses at cycles 41, 81, 121 (a 1-cycle DONE after the last sweep); err_count saturates at 3; fail_vec=0111.

Source files
------------

// File: rtl/nand_sweep_checker.sv
// rtl/nand_sweep_checker.sv - exhaustive 2-bit stimulus sweep and response check for a NAND cell
// Optional: NANDCHK_CONTINUOUS_EN wraps back to vector 0 while start stays high.
module nand_sweep_checker #(
  parameter int HOLD   = 10,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [7:0] SETTLE_IDX = 8'(SETTLE);

  state_t           state_q;
  logic [1:0]       vec_q;
  logic [7:0]       hold_q;
  logic             busy_q, done_q, err_flag_q;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [3:0]       fail_vec_q;
  logic             mismatch;

  // The cell is expected to behave as an ideal NAND of the vector it is driven with.
  assign mismatch    = (dut_out != ~(vec_q[0] & vec_q[1]));
  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      hold_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      fail_vec_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= RUN;
            vec_q       <= 2'd0;
            hold_q      <= 8'd0;
            busy_q      <= 1'b1;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            fail_vec_q  <= 4'd0;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (hold_q == SETTLE_IDX && mismatch) begin
            err_flag_q         <= 1'b1;
            err_count_q        <= err_count_d;
            fail_vec_q[vec_q]  <= 1'b1;
          end
          if (hold_q == HOLD_LAST) begin
            hold_q <= 8'd0;
            vec_q  <= vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              done_q <= 1'b1;
`ifdef NANDCHK_CONTINUOUS_EN
              if (!start) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end
`else
              state_q <= DONE;
              busy_q  <= 1'b0;
`endif
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          vec_q   <= 2'd0;
        end
      endcase
    end
  end

  assign stim_a    = vec_q[0];
  assign stim_b    = vec_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
